// File: rtl/pipe_hazard_ctl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use stall, redirect flush,
// multi-cycle multiply hold, trap drain and halt. Optional stall counter: HAZ_PERF_CNT_EN.
module pipe_hazard_ctl #(
  parameter int MUL_LAT      = 4,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_r1,
  input  logic [4:0]  id_r2,
  input  logic        id_use_r1,
  input  logic        id_use_r2,
  input  logic [4:0]  ex_destReg,
  input  logic        ex_RegWrite,
  input  logic        ex_MemToReg,
  input  logic        ex_mul,
  input  logic        ex_redirect,
  input  logic        ex_trap,
  input  logic        trap_resume,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        id_ex_stall,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        halted,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {
    S_RUN        = 2'd0,
    S_MUL_BUSY   = 2'd1,
    S_TRAP_DRAIN = 2'd2,
    S_HALT       = 2'd3
  } state_t;

  // The cycle that detects a multiply or trap already stalls/flushes, so the busy
  // states only cover the remaining MUL_LAT-2 and DRAIN_CYCLES-1 cycles.
  localparam int MUL_BUSY_CYC = (MUL_LAT > 2) ? MUL_LAT - 2 : 0;
  localparam int DRAIN_CYC    = (DRAIN_CYCLES > 1) ? DRAIN_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] MUL_LOAD   = CNT_W'(MUL_BUSY_CYC);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_haz_r1, w_haz_r2, w_load_use, w_last;

  assign w_haz_r1   = id_use_r1 && (id_r1 == ex_destReg);
  assign w_haz_r2   = id_use_r2 && (id_r2 == ex_destReg);
  assign w_load_use = id_valid && ex_RegWrite && ex_MemToReg &&
                      (ex_destReg != 5'd0) && (w_haz_r1 || w_haz_r2);
  assign w_last     = (r_cnt <= CNT_ONE);

  // NOTE: every output and next-state signal gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    halted       = 1'b0;
    // NOTE: outputs are combinational, so they are gated by reset to read 0 the moment it asserts.
    if (reset) begin
      unique case (r_state)
        S_RUN: begin
          if (ex_trap) begin
            pc_stall    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (DRAIN_CYC == 0) begin
              w_state_nxt = S_HALT;
            end else begin
              w_state_nxt = S_TRAP_DRAIN;
              w_cnt_nxt   = DRAIN_LOAD;
            end
          end else if (ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (ex_mul && (MUL_LAT > 1)) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_flush = 1'b1;
            if (MUL_BUSY_CYC != 0) begin
              w_state_nxt = S_MUL_BUSY;
              w_cnt_nxt   = MUL_LOAD;
            end
          end else if (w_load_use) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
          end
        end
        S_MUL_BUSY: begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_stall  = 1'b1;
          ex_mem_flush = 1'b1;
          w_cnt_nxt    = r_cnt - CNT_ONE;
          if (w_last) w_state_nxt = S_RUN;
        end
        S_TRAP_DRAIN: begin
          pc_stall    = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          w_cnt_nxt   = r_cnt - CNT_ONE;
          if (w_last) w_state_nxt = S_HALT;
        end
        S_HALT: begin
          halted      = 1'b1;
          pc_stall    = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          if (trap_resume) w_state_nxt = S_RUN;
        end
        default: w_state_nxt = S_RUN;
      endcase
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cycles <= '0;
    end else if (pc_stall && (r_state != S_HALT)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Self-checking bench for pipe_hazard_ctl: two instances (MUL_LAT=4/DRAIN=3 and
// MUL_LAT=1/DRAIN=1) share stimulus and are compared against a cycle-count model.
module tb_pipe_hazard_ctl;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_use_r1, id_use_r2;
  logic [4:0]  id_r1, id_r2, ex_destReg;
  logic        ex_RegWrite, ex_MemToReg, ex_mul, ex_redirect, ex_trap, trap_resume;
  logic [1:0]  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_flush, halted;
  logic [31:0] stall_cycles [2];

  int total = 0;
  int bad   = 0;

  // Model: instance 0 is MUL_LAT=4/DRAIN=3, instance 1 is MUL_LAT=1/DRAIN=1.
  int          mul_lat_m [2];
  int          drain_m   [2];
  bit          halt_m    [2];
  int          drain_left[2];
  int          mul_left  [2];
  logic [31:0] perf_m    [2];
  int          obs_stall [2];
  int          obs_pre   [2];

  always #5 clk = ~clk;

  pipe_hazard_ctl #(.MUL_LAT(4), .DRAIN_CYCLES(3), .CNT_W(4)) u_dut_a (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_r1(id_r1), .id_r2(id_r2),
    .id_use_r1(id_use_r1), .id_use_r2(id_use_r2), .ex_destReg(ex_destReg),
    .ex_RegWrite(ex_RegWrite), .ex_MemToReg(ex_MemToReg), .ex_mul(ex_mul),
    .ex_redirect(ex_redirect), .ex_trap(ex_trap), .trap_resume(trap_resume),
    .pc_stall(pc_stall[0]), .if_id_stall(if_id_stall[0]), .if_id_flush(if_id_flush[0]),
    .id_ex_stall(id_ex_stall[0]), .id_ex_flush(id_ex_flush[0]),
    .ex_mem_flush(ex_mem_flush[0]), .halted(halted[0]), .stall_cycles(stall_cycles[0])
  );

  pipe_hazard_ctl #(.MUL_LAT(1), .DRAIN_CYCLES(1), .CNT_W(4)) u_dut_b (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_r1(id_r1), .id_r2(id_r2),
    .id_use_r1(id_use_r1), .id_use_r2(id_use_r2), .ex_destReg(ex_destReg),
    .ex_RegWrite(ex_RegWrite), .ex_MemToReg(ex_MemToReg), .ex_mul(ex_mul),
    .ex_redirect(ex_redirect), .ex_trap(ex_trap), .trap_resume(trap_resume),
    .pc_stall(pc_stall[1]), .if_id_stall(if_id_stall[1]), .if_id_flush(if_id_flush[1]),
    .id_ex_stall(id_ex_stall[1]), .id_ex_flush(id_ex_flush[1]),
    .ex_mem_flush(ex_mem_flush[1]), .halted(halted[1]), .stall_cycles(stall_cycles[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit load_use_m();
    bit m1, m2;
    m1 = id_use_r1 && (id_r1 == ex_destReg);
    m2 = id_use_r2 && (id_r2 == ex_destReg);
    return id_valid && ex_RegWrite && ex_MemToReg && (ex_destReg != 5'd0) && (m1 || m2);
  endfunction

  task automatic idle_inputs();
    id_valid = 0; id_use_r1 = 0; id_use_r2 = 0; id_r1 = 0; id_r2 = 0;
    ex_destReg = 0; ex_RegWrite = 0; ex_MemToReg = 0; ex_mul = 0;
    ex_redirect = 0; ex_trap = 0; trap_resume = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      halt_m[i] = 0; drain_left[i] = 0; mul_left[i] = 0; perf_m[i] = 0;
    end
  endtask

  // Compare every output of both instances against the model, then advance the model.
  task automatic eval_cycle();
    for (int i = 0; i < 2; i++) begin
      bit e_pc = 0, e_ifs = 0, e_iff = 0, e_ies = 0, e_ief = 0, e_emf = 0, e_halt = 0;
      bit was_halt;
      was_halt = halt_m[i];
      if (halt_m[i]) begin
        e_halt = 1; e_pc = 1; e_iff = 1; e_ief = 1;
        if (trap_resume) halt_m[i] = 0;
      end else if (drain_left[i] > 0) begin
        e_pc = 1; e_iff = 1; e_ief = 1;
        drain_left[i]--;
        if (drain_left[i] == 0) halt_m[i] = 1;
      end else if (mul_left[i] > 0) begin
        e_pc = 1; e_ifs = 1; e_ies = 1; e_emf = 1;
        mul_left[i]--;
      end else if (ex_trap) begin
        e_pc = 1; e_iff = 1; e_ief = 1;
        drain_left[i] = drain_m[i] - 1;
        if (drain_left[i] == 0) halt_m[i] = 1;
      end else if (ex_redirect) begin
        e_iff = 1; e_ief = 1;
      end else if (ex_mul && mul_lat_m[i] > 1) begin
        e_pc = 1; e_ifs = 1; e_ies = 1; e_emf = 1;
        mul_left[i] = mul_lat_m[i] - 2;
      end else if (load_use_m()) begin
        e_pc = 1; e_ifs = 1; e_ief = 1;
      end
      check($sformatf("pc_stall[%0d]", i),     32'(pc_stall[i]),     32'(e_pc));
      check($sformatf("if_id_stall[%0d]", i),  32'(if_id_stall[i]),  32'(e_ifs));
      check($sformatf("if_id_flush[%0d]", i),  32'(if_id_flush[i]),  32'(e_iff));
      check($sformatf("id_ex_stall[%0d]", i),  32'(id_ex_stall[i]),  32'(e_ies));
      check($sformatf("id_ex_flush[%0d]", i),  32'(id_ex_flush[i]),  32'(e_ief));
      check($sformatf("ex_mem_flush[%0d]", i), 32'(ex_mem_flush[i]), 32'(e_emf));
      check($sformatf("halted[%0d]", i),       32'(halted[i]),       32'(e_halt));
`ifdef HAZ_PERF_CNT_EN
      check($sformatf("stall_cycles[%0d]", i), stall_cycles[i], perf_m[i]);
`else
      check($sformatf("stall_cycles[%0d]", i), stall_cycles[i], 32'd0);
`endif
      if (e_pc && !was_halt) perf_m[i] = perf_m[i] + 32'd1;
      obs_stall[i] += int'(pc_stall[i]);
      obs_pre[i]   += int'(pc_stall[i] && !halted[i]);
    end
  endtask

  // Inputs are set just after a rising edge; outputs are sampled on the falling edge.
  task automatic cycle();
    @(negedge clk);
    eval_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s pc_stall[%0d]", tag, i), 32'(pc_stall[i]), 32'd0);
      check($sformatf("%s stalls[%0d]", tag, i),
            32'({if_id_stall[i], id_ex_stall[i]}), 32'd0);
      check($sformatf("%s flushes[%0d]", tag, i),
            32'({if_id_flush[i], id_ex_flush[i], ex_mem_flush[i]}), 32'd0);
      check($sformatf("%s halted[%0d]", tag, i), 32'(halted[i]), 32'd0);
      check($sformatf("%s stall_cycles[%0d]", tag, i), stall_cycles[i], 32'd0);
    end
  endtask

  task automatic clear_obs();
    for (int i = 0; i < 2; i++) begin
      obs_stall[i] = 0; obs_pre[i] = 0;
    end
  endtask

  task automatic set_load_use(input logic [4:0] dest);
    idle_inputs();
    id_valid = 1; id_r1 = 5'd5; id_use_r1 = 1; id_r2 = 5'd9;
    ex_destReg = dest; ex_RegWrite = 1; ex_MemToReg = 1;
  endtask

  initial begin
    mul_lat_m = '{4, 1};
    drain_m   = '{3, 1};
    model_reset();
    clear_obs();

    // Reset with an active hazard and multiply on the inputs: outputs must stay 0.
    reset = 0;
    set_load_use(5'd5);
    ex_mul = 1;
    #12;
    check_all_zero("in_reset");
    idle_inputs();
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    #1;
    repeat (2) cycle();

    // Load-use on r1=5: exactly one stall cycle, then the bubble clears it.
    clear_obs();
    set_load_use(5'd5);
    cycle();
    idle_inputs();
    repeat (2) cycle();
    check("loaduse_stall_cnt[0]", 32'(obs_stall[0]), 32'd1);
    check("loaduse_stall_cnt[1]", 32'(obs_stall[1]), 32'd1);

    // Same pattern against r0: never a hazard.
    clear_obs();
    set_load_use(5'd0);
    id_r1 = 5'd0;
    cycle();
    idle_inputs();
    cycle();
    check("r0_stall_cnt", 32'(obs_stall[0] + obs_stall[1]), 32'd0);

    // Multiply: MUL_LAT=4 stalls 3 cycles, MUL_LAT=1 stalls none.
    clear_obs();
    ex_mul = 1;
    cycle();
    ex_mul = 0;
    repeat (5) cycle();
    check("mul_stall_cnt[0]", 32'(obs_stall[0]), 32'd3);
    check("mul_stall_cnt[1]", 32'(obs_stall[1]), 32'd0);
`ifdef HAZ_PERF_CNT_EN
    check("perf_after_mul[0]", stall_cycles[0], 32'd4);
    check("perf_after_mul[1]", stall_cycles[1], 32'd1);
`else
    check("perf_after_mul[0]", stall_cycles[0], 32'd0);
    check("perf_after_mul[1]", stall_cycles[1], 32'd0);
`endif

    // Redirect together with a load-use match: flush only, no stall, one cycle.
    clear_obs();
    set_load_use(5'd5);
    ex_redirect = 1;
    cycle();
    idle_inputs();
    cycle();
    check("redirect_stall_cnt", 32'(obs_stall[0] + obs_stall[1]), 32'd0);

    // Trap with redirect: DRAIN_CYCLES flush cycles, then halted until trap_resume.
    clear_obs();
    ex_trap = 1;
    ex_redirect = 1;
    cycle();
    idle_inputs();
    repeat (6) cycle();
    check("drain_cnt[0]", 32'(obs_pre[0]), 32'd3);
    check("drain_cnt[1]", 32'(obs_pre[1]), 32'd1);
    check("halt_held", 32'(halted), 32'd3);
    trap_resume = 1;
    cycle();
    trap_resume = 0;
    repeat (2) cycle();
    check("halt_cleared", 32'(halted), 32'd0);

    // Reset asserted inside the second MUL_BUSY cycle aborts the multiply.
    ex_mul = 1;
    cycle();
    ex_mul = 0;
    cycle();
    #2;
    check("mul_busy2_stall", 32'(pc_stall[0]), 32'd1);
    reset = 0;
    #1;
    check_all_zero("mid_mul_reset");
    model_reset();
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    #1;
    clear_obs();
    repeat (4) cycle();
    check("post_reset_stall_cnt", 32'(obs_stall[0] + obs_stall[1]), 32'd0);

    // Randomized traffic with a small register range so hazards are frequent.
    for (int n = 0; n < 800; n++) begin
      id_valid    = ($urandom_range(0, 3) != 0);
      id_r1       = 5'($urandom_range(0, 5));
      id_r2       = 5'($urandom_range(0, 5));
      id_use_r1   = 1'($urandom_range(0, 1));
      id_use_r2   = 1'($urandom_range(0, 1));
      ex_destReg  = 5'($urandom_range(0, 5));
      ex_RegWrite = ($urandom_range(0, 3) != 0);
      ex_MemToReg = 1'($urandom_range(0, 1));
      ex_mul      = ($urandom_range(0, 7) == 0);
      ex_redirect = ($urandom_range(0, 7) == 0);
      ex_trap     = ($urandom_range(0, 39) == 0);
      trap_resume = ($urandom_range(0, 5) == 0);
      cycle();
    end
    idle_inputs();
    trap_resume = 1;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
